// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes keypad columns, debounces one tracked key per frame, queues confirmed key codes
// ports: clk, rst (sync, active-high); fila[ROWS] async row lines; col[COLS] one-hot strobe;
//        key_code/key_valid/key_ready FIFO head handshake; key_down tracked-key level; overflow sticky drop flag
module keypad_scanner #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int SCAN_DIV = 65536,
  parameter int DEBOUNCE = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int KW = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] fila,
  output logic [COLS-1:0] col,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_down,
  output logic            overflow
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;
  state_t state, state_n;
  logic [ROWS-1:0] s1, s2;
  logic [DW-1:0] dcnt;
  logic [CW-1:0] cidx, tc, tc_n;
  logic [RW-1:0] row, tr, tr_n;
  logic [KW-1:0] code, t, t_n, push_d;
  logic [3:0] n, n_n;
  logic tick, hit, present, at_col, push_n, push_q;
  logic [KW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic full, pop, wr;
  assign tick = dcnt == DW'(SCAN_DIV - 1);
  assign hit = |s2;
  assign code = KW'(int'(cidx) * ROWS + int'(row));
  assign present = s2[tr];
  assign at_col = cidx == tc;
  assign key_down = state == PRESSED || state == REL;
  // lowest set row wins when several rows are high
  always_comb begin
    row = '0;
    for (int i = ROWS - 1; i >= 0; i--) if (s2[i]) row = RW'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      dcnt <= '0;
      cidx <= '0;
      col <= COLS'(1);
      state <= IDLE;
      t <= '0;
      tc <= '0;
      tr <= '0;
      n <= '0;
      push_q <= 1'b0;
      push_d <= '0;
    end else begin
      s1 <= fila;
      s2 <= s1;
      dcnt <= tick ? '0 : dcnt + 1'b1;
      if (tick) begin
        col <= {col[COLS-2:0], col[COLS-1]};
        cidx <= cidx == CW'(COLS - 1) ? '0 : cidx + 1'b1;
      end
      state <= state_n;
      t <= t_n;
      tc <= tc_n;
      tr <= tr_n;
      n <= n_n;
      push_q <= push_n;
      push_d <= t_n;
    end
  end
  // debounce FSM advances only on ticks; the tracked key is judged only at its own column
  always_comb begin
    state_n = state;
    t_n = t;
    tc_n = tc;
    tr_n = tr;
    n_n = n;
    push_n = 1'b0;
    if (tick)
      case (state)
        IDLE: if (hit) begin
          t_n = code;
          tc_n = cidx;
          tr_n = row;
          n_n = 4'd1;
          state_n = DEBOUNCE == 1 ? PRESSED : CAND;
          push_n = DEBOUNCE == 1;
        end
        CAND: if (at_col) begin
          if (!present) state_n = IDLE;
          else if (n + 4'd1 == 4'(DEBOUNCE)) begin
            state_n = PRESSED;
            push_n = 1'b1;
            n_n = '0;
          end else n_n = n + 4'd1;
        end
        PRESSED: if (at_col && !present) begin
          n_n = 4'd1;
          state_n = DEBOUNCE == 1 ? IDLE : REL;
        end
        REL: if (at_col) begin
          if (present) begin
            n_n = '0;
            state_n = PRESSED;
          end else if (n + 4'd1 == 4'(DEBOUNCE)) begin
            n_n = '0;
            state_n = IDLE;
          end else n_n = n + 4'd1;
        end
        default: state_n = IDLE;
      endcase
  end
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign key_valid = cnt != '0;
  assign pop = key_valid & key_ready;
  // a push into a full FIFO is dropped even when a pop frees a slot that cycle
  assign wr = push_q & ~full;
  assign key_code = key_valid ? mem[rp] : '0;
  always_ff @(posedge clk) if (wr) mem[wp] <= push_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
      overflow <= overflow | (push_q & full);
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: frame-level reference model of the keypad scanner driven by a simulated key matrix
module tb_keypad_scanner;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEB = 3, DEPTH = 4;
  localparam int KW = $clog2(ROWS * COLS);
  logic clk, rst, key_ready, key_valid, key_down, overflow;
  logic [ROWS-1:0] fila;
  logic [COLS-1:0] col;
  logic [KW-1:0] key_code;
  logic [ROWS-1:0] mat [COLS];
  int checks = 0, errors = 0;
  int tk, m_phase, m_t, m_n, m_ovf;
  int q[$];
  int codes[16];

  keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fila(fila), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_down(key_down), .overflow(overflow)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // the strobed column drives the rows of every pressed key in it
  always_comb begin
    fila = '0;
    for (int c = 0; c < COLS; c++) if (col[c]) fila = fila | mat[c];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int code);
    if (q.size() == DEPTH) m_ovf = 1;
    else q.push_back(code);
  endtask

  // phases: 0 idle, 1 candidate, 2 pressed, 3 releasing; judged once per frame at the tracked column
  task automatic model_tick();
    int c, low;
    bit pres, here;
    c = tk % COLS;
    low = -1;
    for (int r = ROWS - 1; r >= 0; r--) if (mat[c][r]) low = r;
    here = c == m_t / ROWS;
    pres = mat[c][m_t % ROWS];
    case (m_phase)
      0: if (low >= 0) begin
        m_t = c * ROWS + low;
        m_n = 1;
        if (DEB == 1) begin m_phase = 2; push(m_t); end
        else m_phase = 1;
      end
      1: if (here) begin
        if (!pres) m_phase = 0;
        else begin
          m_n++;
          if (m_n == DEB) begin m_phase = 2; m_n = 0; push(m_t); end
        end
      end
      2: if (here && !pres) begin m_n = 1; m_phase = DEB == 1 ? 0 : 3; end
      default: if (here) begin
        if (pres) begin m_n = 0; m_phase = 2; end
        else begin m_n++; if (m_n == DEB) m_phase = 0; end
      end
    endcase
    tk++;
  endtask

  task automatic do_reset();
    rst = 1;
    key_ready = 0;
    for (int c = 0; c < COLS; c++) mat[c] = '0;
    repeat (2) @(negedge clk);
    chk("rst_col", col, 1);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_down", key_down, 0);
    chk("rst_overflow", overflow, 0);
    rst = 0;
    tk = 0; m_phase = 0; m_t = 0; m_n = 0; m_ovf = 0;
    q.delete();
  endtask

  // one dwell: check outputs late in the dwell, optionally pop, then model the tick
  task automatic tick_step(input bit pop_en);
    repeat (SCAN_DIV - 1) @(negedge clk);
    chk("col", col, 1 << (tk % COLS));
    chk("key_valid", key_valid, q.size() > 0);
    if (q.size() > 0) chk("key_code", key_code, q[0]);
    chk("key_down", key_down, m_phase >= 2);
    chk("overflow", overflow, m_ovf);
    if (pop_en && q.size() > 0 && $urandom_range(1, 0) == 1) begin
      key_ready = 1;
      void'(q.pop_front());
    end
    @(negedge clk);
    key_ready = 0;
    model_tick();
  endtask

  task automatic frames(input int nf, input bit pop_en);
    repeat (nf * COLS) tick_step(pop_en);
  endtask

  task automatic align();
    while (tk % COLS != 0) tick_step(0);
  endtask

  // key_ready held high for a whole dwell, popping every cycle
  task automatic drain();
    key_ready = 1;
    for (int i = 0; i < SCAN_DIV; i++) begin
      chk("drain_valid", key_valid, q.size() > 0);
      if (q.size() > 0) chk("drain_code", key_code, q[0]);
      @(negedge clk);
      if (q.size() > 0) void'(q.pop_front());
    end
    key_ready = 0;
    model_tick();
  endtask

  task automatic set_key(input int code, input bit v);
    mat[code / ROWS][code % ROWS] = v;
  endtask

  initial begin
    do_reset();
    set_key(6, 1);
    frames(3, 0);
    chk("hold_valid", key_valid, 1);
    chk("hold_code", key_code, 6);
    chk("hold_down", key_down, 1);
    set_key(6, 0);
    frames(2, 0);
    chk("rel_down_mid", key_down, 1);
    frames(1, 0);
    chk("rel_down_end", key_down, 0);
    chk("one_code", key_code, 6);
    drain();
    chk("drained_single", key_valid, 0);

    align();
    set_key(6, 1);
    frames(1, 0);
    set_key(6, 0);
    frames(2, 0);
    chk("short_press", key_valid, 0);

    align();
    set_key(6, 1);
    frames(3, 0);
    set_key(6, 0);
    frames(2, 0);
    set_key(6, 1);
    frames(2, 0);
    chk("bounce_down", key_down, 1);
    drain();
    chk("bounce_single", key_valid, 0);
    set_key(6, 0);
    frames(4, 0);

    align();
    set_key(6, 1);
    set_key(13, 1);
    frames(4, 0);
    chk("dual_code", key_code, 6);
    set_key(6, 0);
    set_key(13, 0);
    frames(4, 0);
    drain();
    chk("dual_single", key_valid, 0);

    for (int i = 0; i < 16; i++) codes[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j, tmp;
      j = int'($urandom_range(i, 0));
      tmp = codes[i]; codes[i] = codes[j]; codes[j] = tmp;
    end
    for (int i = 0; i < 5; i++) begin
      set_key(codes[i], 1);
      frames(3, 0);
      set_key(codes[i], 0);
      frames(4, 0);
    end
    chk("full_overflow", overflow, 1);
    chk("full_head", key_code, codes[0]);
    drain();
    chk("full_drained", key_valid, 0);
    chk("overflow_sticky", overflow, 1);

    set_key(codes[5], 1);
    frames(3, 0);
    set_key(codes[5], 0);
    frames(4, 0);
    chk("pre_rst_valid", key_valid, 1);
    set_key(codes[6], 1);
    frames(1, 0);
    do_reset();
    frames(4, 0);
    chk("post_rst_valid", key_valid, 0);

    for (int i = 0; i < 20; i++) begin
      int k;
      k = int'($urandom_range(ROWS * COLS - 1, 0));
      set_key(k, 1);
      frames(int'($urandom_range(4, 1)), 1);
      set_key(k, 0);
      frames(int'($urandom_range(4, 1)), 1);
    end
    frames(4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
